// File: rtl/lcd_pkg.sv
// Shared types, timing defaults and helpers for the HD44780 read-side controller.
// Defaults assume a 50 MHz clock.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ENH   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } lcd_rd_state_t;

  localparam int SETUP_CYC_DEF = 3;
  localparam int EN_CYC_DEF    = 16;
  localparam int HOLD_CYC_DEF  = 2;
  localparam int GAP_CYC_DEF   = 32;
  localparam int MAX_POLLS_DEF = 1024;

  localparam int BF_BIT     = 7;
  localparam int TMR_W      = 8;
  localparam int POLL_CNT_W = 11;

  // Timed states run for n cycles by loading n-1 and leaving when the timer reads zero.
  function automatic logic [TMR_W-1:0] cyc_load(input int n);
    return TMR_W'(n - 1);
  endfunction

endpackage

// File: rtl/lcd_rd_timer.sv
// Loadable down-counter with zero flag; one instance paces every timed state of the read FSM.
module lcd_rd_timer
  import lcd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_value,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/lcd_read_controller.sv
// HD44780 read controller: single BF/AC or data reads, optional busy-flag polling.
// Optional macro LCD_RD_TIMEOUT_EN bounds polling to MAX_POLLS reads and reports oTIMEOUT.
module lcd_read_controller
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int EN_CYC    = EN_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
`ifdef LCD_RD_TIMEOUT_EN
  ,
  parameter int MAX_POLLS = MAX_POLLS_DEF
`endif
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPOLL,
  output logic       oDone,
  output logic [7:0] oDATA,
  output logic       oBUSY,
  output logic       oTIMEOUT,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam logic [TMR_W-1:0] LD_SETUP = cyc_load(SETUP_CYC);
  localparam logic [TMR_W-1:0] LD_EN    = cyc_load(EN_CYC);
  localparam logic [TMR_W-1:0] LD_HOLD  = cyc_load(HOLD_CYC);
  localparam logic [TMR_W-1:0] LD_GAP   = cyc_load(GAP_CYC);

  lcd_rd_state_t    r_state;
  logic             r_start_d;
  logic             r_done;
  logic             r_busy;
  logic             r_rw;
  logic             r_en;
  logic             r_rs;
  logic             r_poll_mode;
  logic [7:0]       r_data;

  logic             w_start;
  logic             w_accept;
  logic             w_tmr_zero;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_value;
  logic             w_poll_limit;
  logic             w_poll_again;

  // The bus belongs to the LCD during reads; this block only ever listens.
  assign LCD_DATA = 8'hzz;

  assign w_start      = iStart & ~r_start_d;
  assign w_accept     = w_start && (r_state == ST_IDLE);
  assign w_poll_again = r_poll_mode && r_data[BF_BIT] && !w_poll_limit;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= iStart;
    end
  end

  // Load the timer on the same edge that enters each timed state.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tmr_zero) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_EN;
        end
      end
      ST_ENH: begin
        if (w_tmr_zero) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_tmr_zero && w_poll_again) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_GAP;
        end
      end
      ST_GAP: begin
        if (w_tmr_zero) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_SETUP;
        end
      end
      default: begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
      end
    endcase
  end

  lcd_rd_timer u_timer (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_zero  (w_tmr_zero)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_rw        <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_poll_mode <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_SETUP;
            r_busy      <= 1'b1;
            r_rw        <= 1'b1;
            r_rs        <= iPOLL ? 1'b0 : iRS;
            r_poll_mode <= iPOLL;
          end
        end
        ST_SETUP: begin
          if (w_tmr_zero) begin
            r_state <= ST_ENH;
            r_en    <= 1'b1;
          end
        end
        ST_ENH: begin
          // Capture while EN is still high so the LCD output is guaranteed valid.
          if (w_tmr_zero) begin
            r_state <= ST_HOLD;
            r_en    <= 1'b0;
            r_data  <= LCD_DATA;
          end
        end
        ST_HOLD: begin
          if (w_tmr_zero) begin
            r_rw <= 1'b0;
            if (w_poll_again) begin
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (w_tmr_zero) begin
            r_state <= ST_SETUP;
            r_rw    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_rs    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LCD_RD_TIMEOUT_EN
  localparam logic [POLL_CNT_W:0] POLL_LIMIT = (POLL_CNT_W + 1)'(MAX_POLLS);

  logic [POLL_CNT_W-1:0] r_poll_cnt;
  logic                  r_timeout;

  // Limit is reached when the read now finishing would be read number MAX_POLLS.
  assign w_poll_limit = ({1'b0, r_poll_cnt} + {{POLL_CNT_W{1'b0}}, 1'b1}) >= POLL_LIMIT;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == ST_HOLD && w_tmr_zero && r_poll_mode) begin
      if (!(&r_poll_cnt)) begin
        r_poll_cnt <= r_poll_cnt + 1'b1;
      end
      if (r_data[BF_BIT] && w_poll_limit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign oTIMEOUT = r_timeout;
`else
  assign w_poll_limit = 1'b0;
  assign oTIMEOUT     = 1'b0;
`endif

  assign oDone  = r_done;
  assign oDATA  = r_data;
  assign oBUSY  = r_busy;
  assign LCD_RW = r_rw;
  assign LCD_EN = r_en;
  assign LCD_RS = r_rs;

endmodule

// File: tb/tb_lcd_read_controller.sv
// Directed bench for lcd_read_controller; a bus model answers each EN pulse from a response table.
// Define LCD_RD_TIMEOUT_EN to include the poll-timeout scenario (MAX_POLLS=4).
module tb_lcd_read_controller;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       rs    = 1'b0;
  logic       poll  = 1'b0;
  wire  [7:0] lcd_bus;
  logic       done;
  logic [7:0] data;
  logic       busy;
  logic       timeout;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_rs;

  logic [7:0] resp [0:3];
  logic [7:0] drv_val;
  int         drv_idx;
  int         fall_base = 0;

  int en_rises = 0, en_falls = 0, en_len = 0, last_en_len = 0;
  int low_run = 0, last_gap = 0, setup_run = 0, last_setup = 0;
  int rs_run = 0, last_rs_hold = 0, viol = 0, done_cnt = 0;
  logic en_d = 1'b0, rs_d = 1'b0, last_rs_at_rise = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef LCD_RD_TIMEOUT_EN
  lcd_read_controller #(.MAX_POLLS(4)) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iStart   (start),
    .iRS      (rs),
    .iPOLL    (poll),
    .oDone    (done),
    .oDATA    (data),
    .oBUSY    (busy),
    .oTIMEOUT (timeout),
    .LCD_DATA (lcd_bus),
    .LCD_RW   (lcd_rw),
    .LCD_EN   (lcd_en),
    .LCD_RS   (lcd_rs)
  );
`else
  lcd_read_controller dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iStart   (start),
    .iRS      (rs),
    .iPOLL    (poll),
    .oDone    (done),
    .oDATA    (data),
    .oBUSY    (busy),
    .oTIMEOUT (timeout),
    .LCD_DATA (lcd_bus),
    .LCD_RW   (lcd_rw),
    .LCD_EN   (lcd_en),
    .LCD_RS   (lcd_rs)
  );
`endif

  // LCD model: drives the bus only while a read strobe is active.
  always_comb begin
    drv_idx = en_falls - fall_base;
    if (drv_idx > 3) drv_idx = 3;
    if (drv_idx < 0) drv_idx = 0;
    drv_val = resp[drv_idx];
  end
  assign lcd_bus = (lcd_rw && lcd_en) ? drv_val : 8'hzz;

  // Pin monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (lcd_en && !en_d) begin
      en_rises++;
      en_len          = 1;
      last_gap        = low_run;
      last_setup      = setup_run;
      last_rs_hold    = rs_run;
      last_rs_at_rise = lcd_rs;
    end else if (lcd_en) begin
      en_len++;
    end
    if (!lcd_en && en_d) begin
      en_falls++;
      last_en_len = en_len;
    end
    if (lcd_en && en_d && lcd_rs != rs_d) viol++;
    if (lcd_en && !lcd_rw) viol++;
    if (done) done_cnt++;
    low_run   = lcd_en ? 0 : low_run + 1;
    setup_run = (lcd_rw && !lcd_en) ? setup_run + 1 : 0;
    rs_run    = (lcd_rs == rs_d) ? rs_run + 1 : 1;
    en_d      = lcd_en;
    rs_d      = lcd_rs;
  end

  // Counts negedges until oDone; cyc = -1 if the budget expires.
  task automatic run_txn(input int limit, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    for (int k = 1; k <= limit && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", lcd_en); end
    n_checks++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
    n_checks++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b done=%b timeout=%b expected 0 0 0", busy, done, timeout);
    end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn reset released");
  endtask

  task automatic test_single_bf();
    int c;
    int r0;
    @(negedge clk);
    resp[0] = 8'h25; fall_base = en_falls; r0 = en_rises;
    rs = 1'b0; poll = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (lcd_en !== 1'b1 || lcd_rw !== 1'b1 || lcd_rs !== 1'b0) begin
      n_fail++; $display("FAIL bf_pins: got en=%b rw=%b rs=%b expected 1 1 0", lcd_en, lcd_rw, lcd_rs);
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bf_busy: got %b expected 1", busy); end
    run_txn(40, c);
    if (c > 0) c = c + 10;
    n_checks++; if (c != 22) begin n_fail++; $display("FAIL bf_latency: got %0d expected 22", c); end
    n_checks++; if (data !== 8'h25) begin n_fail++; $display("FAIL bf_data: got %h expected 25", data); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL bf_after: got busy=%b done=%b expected 0 0", busy, done);
    end
    n_checks++; if (last_en_len != 16) begin n_fail++; $display("FAIL bf_en_len: got %0d expected 16", last_en_len); end
    n_checks++; if (en_rises - r0 != 1) begin n_fail++; $display("FAIL bf_pulses: got %0d expected 1", en_rises - r0); end
    start = 1'b0;
    $display("txn single RS=0 done at cycle %0d data=%h", c, data);
  endtask

  task automatic test_single_data();
    int c;
    int v0;
    @(negedge clk);
    resp[0] = 8'h41; fall_base = en_falls; v0 = viol;
    rs = 1'b1; poll = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (lcd_bus !== 8'h41) begin n_fail++; $display("FAIL data_bus: got %h expected 41", lcd_bus); end
    run_txn(40, c);
    if (c > 0) c = c + 10;
    n_checks++; if (c != 22) begin n_fail++; $display("FAIL data_latency: got %0d expected 22", c); end
    n_checks++; if (data !== 8'h41) begin n_fail++; $display("FAIL data_value: got %h expected 41", data); end
    n_checks++; if (last_rs_at_rise !== 1'b1 || last_rs_hold != 3) begin
      n_fail++; $display("FAIL data_rs_setup: got rs=%b held %0d cycles expected 1 held 3", last_rs_at_rise, last_rs_hold);
    end
    n_checks++; if (last_setup != 3) begin n_fail++; $display("FAIL data_rw_setup: got %0d expected 3", last_setup); end
    n_checks++; if (viol != v0) begin n_fail++; $display("FAIL data_stable: got %0d pin changes expected 0", viol - v0); end
    start = 1'b0;
    $display("txn single RS=1 done at cycle %0d data=%h", c, data);
  endtask

  task automatic test_poll();
    int c;
    int r0;
    int d0;
    @(negedge clk);
    resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h07;
    fall_base = en_falls; r0 = en_rises; d0 = done_cnt;
    rs = 1'b1; poll = 1'b1; start = 1'b1;
    run_txn(400, c);
    n_checks++; if (c != 181) begin n_fail++; $display("FAIL poll_latency: got %0d expected 181", c); end
    n_checks++; if (data !== 8'h07) begin n_fail++; $display("FAIL poll_data: got %h expected 07", data); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL poll_timeout: got %b expected 0", timeout); end
    repeat (40) @(negedge clk);
    n_checks++; if (en_rises - r0 != 4) begin n_fail++; $display("FAIL poll_pulses: got %0d expected 4", en_rises - r0); end
    n_checks++; if (last_gap != 37) begin n_fail++; $display("FAIL poll_gap: got %0d low cycles expected 37", last_gap); end
    n_checks++; if (last_rs_at_rise !== 1'b0) begin n_fail++; $display("FAIL poll_rs: got %b expected 0", last_rs_at_rise); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL poll_done_count: got %0d expected 1", done_cnt - d0); end
    start = 1'b0; poll = 1'b0; rs = 1'b0;
    $display("txn poll done at cycle %0d data=%h timeout=%b", c, data, timeout);
  endtask

`ifdef LCD_RD_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    int r0;
    @(negedge clk);
    resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h80;
    fall_base = en_falls; r0 = en_rises;
    poll = 1'b1; start = 1'b1;
    run_txn(400, c);
    n_checks++; if (c != 181) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 181", c); end
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", timeout); end
    n_checks++; if (data !== 8'h80) begin n_fail++; $display("FAIL tmo_data: got %h expected 80", data); end
    repeat (40) @(negedge clk);
    n_checks++; if (en_rises - r0 != 4) begin n_fail++; $display("FAIL tmo_pulses: got %0d expected 4", en_rises - r0); end
    $display("txn poll timeout at cycle %0d data=%h", c, data);
    start = 1'b0; poll = 1'b0;
    @(negedge clk);
    resp[0] = 8'h25; fall_base = en_falls; start = 1'b1;
    @(negedge clk);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", timeout); end
    run_txn(40, c);
    start = 1'b0;
    $display("txn single after timeout done at cycle %0d", c + 1);
  endtask
`endif

  task automatic test_back_to_back();
    int c;
    int d0;
    @(negedge clk);
    resp[0] = 8'h33; fall_base = en_falls; d0 = done_cnt;
    start = 1'b1;
    run_txn(40, c);
    n_checks++; if (c != 22) begin n_fail++; $display("FAIL b2b_first: got %0d expected 22", c); end
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_held_busy: got %b expected 0", busy); end
    $display("txn held start done at cycle %0d", c);
    start = 1'b0;
    @(negedge clk);
    fall_base = en_falls; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    run_txn(40, c);
    if (c > 0) c = c + 6;
    n_checks++; if (c != 22) begin n_fail++; $display("FAIL b2b_second: got %0d expected 22", c); end
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_ignored_edge: got %0d completions expected 2", done_cnt - d0); end
    $display("txn restart with busy edge done at cycle %0d", c);
    start = 1'b0;
    @(negedge clk);
    resp[0] = 8'h5a; fall_base = en_falls; start = 1'b1;
    run_txn(40, c);
    n_checks++; if (c != 22 || data !== 8'h5a) begin
      n_fail++; $display("FAIL b2b_third: got cycle %0d data %h expected 22 5a", c, data);
    end
    start = 1'b0;
    $display("txn idle edge done at cycle %0d data=%h", c, data);
  endtask

  task automatic test_reset_mid();
    int c;
    int d0;
    @(negedge clk);
    resp[0] = 8'h6c; fall_base = en_falls; d0 = done_cnt;
    start = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (lcd_en !== 1'b0 || lcd_rw !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pins: got en=%b rw=%b expected 0 0", lcd_en, lcd_rw);
    end
    n_checks++; if (busy !== 1'b0 || data !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_state: got busy=%b data=%h expected 0 00", busy, data);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d completions expected 0", done_cnt - d0); end
    $display("txn aborted by reset");
    fall_base = en_falls; start = 1'b1;
    run_txn(40, c);
    n_checks++; if (c != 22 || data !== 8'h6c) begin
      n_fail++; $display("FAIL rstmid_recover: got cycle %0d data %h expected 22 6c", c, data);
    end
    start = 1'b0;
    $display("txn after reset done at cycle %0d data=%h", c, data);
  endtask

  initial begin
    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h00;
    test_reset();
    test_single_bf();
    test_single_data();
    test_poll();
`ifdef LCD_RD_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
